// File: rtl/rx_deframer.sv
// rx_deframer -- serial bit-stream deframer.
//   Hunts for PREAMBLE_ZEROS consecutive zero bits, then searches for the SFD
//   octet (LSB-first) for at most SFD_TIMEOUT bits, reads an 8-bit PHR whose
//   low 7 bits give the frame length in octets, and emits 2*length payload
//   nibbles (LSB-first) as single-cycle FIFO writes.
// Ports:
//   inClock, inReset     clock, synchronous active-high reset
//   inBitValid, inBit    recovered-bit strobe and bit from the CDR
//   inFifoFull           output FIFO full; a nibble completing while full is dropped
//   outWriteEnable       FIFO write strobe, one cycle after the nibble's 4th bit
//   outData[3:0]         payload nibble, valid with outWriteEnable
//   outSync              high from SFD match until frame end
//   outLength[6:0]       PHR length, held until the next PHR
//   outFrameDone         pulse with the last nibble (written or dropped)
//   outOverflow          sticky drop flag, cleared on the next SFD match
//   outCrcOk             FCS result, valid with outFrameDone
// Build option: define RX_DEFRAMER_CRC_EN to compile in the serial CRC-16
//   (x^16+x^12+x^5+1, init 0) check over all payload bits, FCS included.
//   Without it outCrcOk is tied to 1.
module rx_deframer #(
  parameter int         PREAMBLE_ZEROS = 32,
  parameter logic [7:0] SFD            = 8'hA7,
  parameter int         SFD_TIMEOUT    = 24
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inBitValid,
  input  logic       inBit,
  input  logic       inFifoFull,
  output logic       outWriteEnable,
  output logic [3:0] outData,
  output logic       outSync,
  output logic [6:0] outLength,
  output logic       outFrameDone,
  output logic       outOverflow,
  output logic       outCrcOk
);

  localparam int ZW = $clog2(PREAMBLE_ZEROS + 1);
  localparam int TW = $clog2(SFD_TIMEOUT + 1);

  // The bare name SFD belongs to the delimiter parameter, so the search
  // state is SFD_SEARCH.
  typedef enum logic [1:0] {HUNT, SFD_SEARCH, LENGTH, PAYLOAD} stateT;

  stateT         state;
  logic [ZW-1:0] zeroCnt;
  logic [TW-1:0] sfdCnt;
  logic [6:0]    sfdReg;     // last 7 bits seen; the 8th comes from inBit
  logic [6:0]    lenShift;   // PHR bits 0..6; bit 7 is never stored
  logic [2:0]    lenBitCnt;
  logic [2:0]    nibReg;     // first 3 bits of the nibble being assembled
  logic [1:0]    nibBitCnt;
  logic [7:0]    nibCnt;

  logic [7:0] sfdNext;
  logic [3:0] nibNext;
  logic       lastNib;

  assign sfdNext = {inBit, sfdReg};
  assign nibNext = {inBit, nibReg};
  assign lastNib = (nibCnt == ({outLength, 1'b0} - 8'd1));

`ifdef RX_DEFRAMER_CRC_EN
  logic [15:0] crc;
  logic [15:0] crcNext;
  assign crcNext = {crc[14:0], 1'b0} ^ ((crc[15] ^ inBit) ? 16'h1021 : 16'h0000);
`else
  assign outCrcOk = 1'b1;
`endif

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state          <= HUNT;
      zeroCnt        <= '0;
      sfdCnt         <= '0;
      sfdReg         <= '0;
      lenShift       <= '0;
      lenBitCnt      <= '0;
      nibReg         <= '0;
      nibBitCnt      <= '0;
      nibCnt         <= '0;
      outWriteEnable <= 1'b0;
      outData        <= '0;
      outSync        <= 1'b0;
      outLength      <= '0;
      outFrameDone   <= 1'b0;
      outOverflow    <= 1'b0;
`ifdef RX_DEFRAMER_CRC_EN
      crc            <= '0;
      outCrcOk       <= 1'b1;
`endif
    end else begin
      outWriteEnable <= 1'b0;
      outFrameDone   <= 1'b0;
      if (inBitValid) begin
        case (state)
          HUNT: begin
            if (inBit) begin
              zeroCnt <= '0;
            end else if (zeroCnt == ZW'(PREAMBLE_ZEROS - 1)) begin
              zeroCnt <= '0;
              sfdCnt  <= '0;
              sfdReg  <= '0;
              state   <= SFD_SEARCH;
            end else begin
              zeroCnt <= zeroCnt + 1'b1;
            end
          end

          SFD_SEARCH: begin
            sfdReg <= sfdNext[7:1];
            if (sfdNext == SFD) begin
              state       <= LENGTH;
              lenBitCnt   <= '0;
              outSync     <= 1'b1;
              outOverflow <= 1'b0;
`ifdef RX_DEFRAMER_CRC_EN
              crc         <= '0;
`endif
            end else if (sfdCnt == TW'(SFD_TIMEOUT - 1)) begin
              state   <= HUNT;
              sfdCnt  <= '0;
              sfdReg  <= '0;
              zeroCnt <= '0;
            end else begin
              sfdCnt <= sfdCnt + 1'b1;
            end
          end

          LENGTH: begin
            lenBitCnt <= lenBitCnt + 1'b1;
            if (lenBitCnt == 3'd7) begin
              // 8th bit is PHR bit 7 and is discarded.
              outLength <= lenShift;
              if (lenShift == 7'd0) begin
                state   <= HUNT;
                outSync <= 1'b0;
              end else begin
                state     <= PAYLOAD;
                nibBitCnt <= '0;
                nibCnt    <= '0;
              end
            end else begin
              lenShift <= {inBit, lenShift[6:1]};
            end
          end

          PAYLOAD: begin
            nibReg    <= nibNext[3:1];
            nibBitCnt <= nibBitCnt + 1'b1;
`ifdef RX_DEFRAMER_CRC_EN
            crc       <= crcNext;
`endif
            if (nibBitCnt == 2'd3) begin
              nibCnt <= nibCnt + 1'b1;
              if (inFifoFull) begin
                outOverflow <= 1'b1;
              end else begin
                outWriteEnable <= 1'b1;
                outData        <= nibNext;
              end
              if (lastNib) begin
                outFrameDone <= 1'b1;
                outSync      <= 1'b0;
                state        <= HUNT;
`ifdef RX_DEFRAMER_CRC_EN
                outCrcOk     <= (crcNext == 16'h0000);
`endif
              end
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer -- randomized self-checking bench for rx_deframer.
// Frames are described at octet level (payload bytes, per-nibble FIFO-full
// flags); expected nibbles, frame-done position, overflow and CRC result are
// derived from those bytes, and every DUT response is checked on the falling
// edge after each bit.
module tb_rx_deframer;

  logic       inClock = 1'b0;
  logic       inReset = 1'b1;
  logic       inBitValid = 1'b0;
  logic       inBit = 1'b0;
  logic       inFifoFull = 1'b0;
  logic       outWriteEnable;
  logic [3:0] outData;
  logic       outSync;
  logic [6:0] outLength;
  logic       outFrameDone;
  logic       outOverflow;
  logic       outCrcOk;

  localparam logic [7:0] SFD_V = 8'hA7;

  int total = 0;
  int bad   = 0;
  int gapMax = 0;

  logic [7:0] pay[$];
  logic       fullNib[$];

  rx_deframer #(.PREAMBLE_ZEROS(32), .SFD(8'hA7), .SFD_TIMEOUT(24)) dut (
    .inClock(inClock), .inReset(inReset), .inBitValid(inBitValid),
    .inBit(inBit), .inFifoFull(inFifoFull),
    .outWriteEnable(outWriteEnable), .outData(outData), .outSync(outSync),
    .outLength(outLength), .outFrameDone(outFrameDone),
    .outOverflow(outOverflow), .outCrcOk(outCrcOk)
  );

  always #5 inClock = ~inClock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

`ifdef RX_DEFRAMER_CRC_EN
  // CRC-16 long division over the payload bits in wire order.
  function automatic logic [15:0] crcOf();
    logic [15:0] c;
    logic [7:0]  b;
    c = '0;
    foreach (pay[j]) begin
      b = pay[j];
      for (int i = 0; i < 8; i++)
        c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Append the FCS so that its register MSB goes on the wire first.
  task automatic appendFcs();
    logic [15:0] c;
    logic [7:0]  b0, b1;
    c = crcOf();
    for (int i = 0; i < 8; i++) begin
      b0[i] = c[15 - i];
      b1[i] = c[7 - i];
    end
    pay.push_back(b0);
    pay.push_back(b1);
  endtask
`endif

  function automatic logic expCrcOk();
`ifdef RX_DEFRAMER_CRC_EN
    return (crcOf() == 16'h0000);
`else
    return 1'b1;
`endif
  endfunction

  // Drive one bit for one cycle, then check the registered response.
  task automatic sendBit(input logic b, input logic f, input logic expWe,
                         input logic [3:0] expData, input logic expDone);
    int n;
    inBitValid = 1'b1; inBit = b; inFifoFull = f;
    @(negedge inClock);
    inBitValid = 1'b0; inBit = 1'b0; inFifoFull = 1'b0;
    chk("we", outWriteEnable, expWe);
    if (expWe) chk("data", outData, expData);
    chk("done", outFrameDone, expDone);
    n = $urandom_range(0, gapMax);
    repeat (n) begin
      @(negedge inClock);
      chk("we_gap", outWriteEnable, 1'b0);
      chk("done_gap", outFrameDone, 1'b0);
    end
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sendBit(v[i], noise(), 1'b0, 4'h0, 1'b0);
  endtask

  task automatic sendZeros(input int n);
    for (int i = 0; i < n; i++) sendBit(1'b0, noise(), 1'b0, 4'h0, 1'b0);
  endtask

  task automatic checkIdle();
    chk("rst_we", outWriteEnable, 1'b0);
    chk("rst_data", outData, 4'h0);
    chk("rst_sync", outSync, 1'b0);
    chk("rst_len", outLength, 7'h0);
    chk("rst_done", outFrameDone, 1'b0);
    chk("rst_ovf", outOverflow, 1'b0);
    chk("rst_crc", outCrcOk, 1'b1);
  endtask

  task automatic pulseReset();
    inReset = 1'b1;
    @(negedge inClock);
    inReset = 1'b0;
  endtask

  task automatic fillFull(input int nNib, input int oneIn);
    fullNib.delete();
    for (int i = 0; i < nNib; i++)
      fullNib.push_back(oneIn > 0 && $urandom_range(0, oneIn - 1) == 0);
  endtask

  // Full frame from pay/fullNib; abortNib >= 0 resets just before that nibble.
  task automatic sendFrame(input int nZeros, input logic [7:0] lenByte, input int abortNib);
    int         len;
    logic       anyFull;
    logic [7:0] b;
    logic [3:0] d;
    logic       f;
    sendZeros(nZeros);
    sendByte(SFD_V);
    chk("sync_on", outSync, 1'b1);
    sendByte(lenByte);
    len = int'(lenByte[6:0]);
    chk("len", outLength, lenByte[6:0]);
    if (len == 0) begin
      chk("sync_len0", outSync, 1'b0);
      return;
    end
    anyFull = 1'b0;
    for (int nib = 0; nib < 2 * len; nib++) begin
      if (nib == abortNib) begin
        pulseReset();
        return;
      end
      b = pay[nib / 2];
      d = (nib % 2 == 1) ? b[7:4] : b[3:0];
      f = fullNib[nib];
      for (int k = 0; k < 4; k++) begin
        if (k == 3) sendBit(d[k], f, !f, d, nib == 2 * len - 1);
        else        sendBit(d[k], noise(), 1'b0, 4'h0, 1'b0);
      end
      anyFull |= f;
    end
    chk("sync_off", outSync, 1'b0);
    chk("ovf", outOverflow, anyFull);
    chk("crc", outCrcOk, expCrcOk());
  endtask

  initial begin
    repeat (3) @(negedge inClock);
    checkIdle();
    inReset = 1'b0;
    @(negedge inClock);

    // Reference frame, back-to-back bits: writes A,5,C,3.
    pay = '{8'h5A, 8'h3C}; fillFull(4, 0);
    sendFrame(32, 8'h02, -1);

    // 31 zeros then a one: no preamble, so SFD and what follows are ignored.
    sendZeros(31);
    sendBit(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    sendByte(SFD_V);
    chk("nosync", outSync, 1'b0);
    sendByte(8'h02); sendByte(8'h5A); sendByte(8'h3C);
    chk("nosync2", outSync, 1'b0);

    // SFD timeout: 24 ones after the preamble, then a good frame.
    sendZeros(32);
    for (int i = 0; i < 24; i++) sendBit(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("timeout_sync", outSync, 1'b0);
    gapMax = 2;
    pay = '{8'hC3, 8'h96}; fillFull(4, 0);
    sendFrame(32, 8'h02, -1);

    // FIFO full on the 2nd nibble: A dropped-5, then C,3; overflow set.
    pay = '{8'h5A, 8'h3C}; fullNib = '{1'b0, 1'b1, 1'b0, 1'b0};
    sendFrame(32, 8'h02, -1);
    chk("ovf_sticky", outOverflow, 1'b1);

    // Next frame clears overflow on SFD; PHR bit 7 ignored.
    pay = '{8'hE1}; fillFull(2, 0);
    sendFrame(34, 8'h81, -1);

    // Zero length: no writes, back to hunt.
    pay.delete(); fullNib.delete();
    sendFrame(32, 8'h80, -1);

    // Reset after two payload nibbles, then a clean frame.
    pay = '{8'h5A, 8'h3C}; fullNib = '{1'b1, 1'b0, 1'b0, 1'b0};
    sendFrame(32, 8'h02, 2);
    checkIdle();
    for (int i = 0; i < 6; i++) begin
      @(negedge inClock);
      chk("abort_done", outFrameDone, 1'b0);
    end
    pay = '{8'h12, 8'h34, 8'h56}; fillFull(6, 0);
    sendFrame(32, 8'h03, -1);

`ifdef RX_DEFRAMER_CRC_EN
    pay = '{8'h01}; appendFcs(); fillFull(6, 0);
    sendFrame(32, 8'h03, -1);
    chk("crc_good", outCrcOk, 1'b1);
    pay[2] = pay[2] ^ 8'h10;
    sendFrame(32, 8'h03, -1);
    chk("crc_bad", outCrcOk, 1'b0);
`endif

    // Randomized frames.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(1, 4);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
`ifdef RX_DEFRAMER_CRC_EN
      if ($urandom_range(0, 1) == 1) appendFcs();
`endif
      fillFull(2 * pay.size(), 8);
      sendFrame($urandom_range(32, 40), {noise(), 7'(pay.size())}, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
